// File: rtl/imgproc_pkg.sv
// Purpose: shared types and sizes for the image-processing window path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: DATA_W (bits per pixel), WIN_W (3x3 window width), NUM_LB (line
// buffer count), rd_state_t (window read FSM states).
package imgproc_pkg;
    localparam int DATA_W = 8;
    localparam int WIN_W  = 9 * DATA_W;
    localparam int NUM_LB = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RD   = 1'b1
    } rd_state_t;
endpackage

// File: rtl/window_gen_if.sv
// Purpose: pixel-in / window-out bundle for window_gen.
// Latency: n/a (wiring only).
// Backpressure: none on the window side; the optional o_pixel_ready (present
// when WINDOW_GEN_READY_EN is defined) tells the pixel source to hold its data.
// Modports: slave = window_gen view, master = pixel source / window sink view.
interface window_gen_if;
    import imgproc_pkg::*;

    logic [DATA_W-1:0] i_pixel_data;
    logic              i_pixel_data_valid;
    logic [WIN_W-1:0]  o_pixel_data;
    logic              o_pixel_data_valid;
    logic              o_intr;
`ifdef WINDOW_GEN_READY_EN
    logic              o_pixel_ready;
`endif

    modport slave (
        input  i_pixel_data,
        input  i_pixel_data_valid,
`ifdef WINDOW_GEN_READY_EN
        output o_pixel_ready,
`endif
        output o_pixel_data,
        output o_pixel_data_valid,
        output o_intr
    );

    modport master (
        output i_pixel_data,
        output i_pixel_data_valid,
`ifdef WINDOW_GEN_READY_EN
        input  o_pixel_ready,
`endif
        input  o_pixel_data,
        input  o_pixel_data_valid,
        input  o_intr
    );
endinterface

// File: rtl/window_gen_line_buf.sv
// Purpose: one LINE_WIDTH x DATA_W line store returning three adjacent pixels per read.
// Latency: 1 clk from i_rd_en to o_data (registered read).
// Backpressure: none; the parent gates i_data_valid and i_rd_en.
// Ports: i_clk, i_rst_n (async active-low), i_data/i_data_valid write side,
// i_rd_en read strobe, o_data = pixels rd_ptr..rd_ptr+2 (pixel rd_ptr in the low byte).
module line_buf
    import imgproc_pkg::*;
#(
    parameter int LINE_WIDTH = 512
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_W-1:0]     i_data,
    input  logic                  i_data_valid,
    input  logic                  i_rd_en,
    output logic [3*DATA_W-1:0]   o_data
);
    localparam int PW = $clog2(LINE_WIDTH);

    logic [DATA_W-1:0] mem [LINE_WIDTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    // Storage carries no reset; its contents are meaningless until written.
    always_ff @(posedge i_clk) begin
        if (i_data_valid) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            o_data <= '0;
        end else begin
            if (i_data_valid) begin
                wr_ptr <= (wr_ptr == PW'(LINE_WIDTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (i_rd_en) begin
                o_data <= {mem[rd_ptr + PW'(2)], mem[rd_ptr + PW'(1)], mem[rd_ptr]};
                // The last window of a line starts at LINE_WIDTH-3.
                rd_ptr <= (rd_ptr == PW'(LINE_WIDTH - 3)) ? '0 : rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/window_gen.sv
// Purpose: raster pixel stream -> 3x3 windows from four rotating line buffers, with a per-line o_intr pulse.
// Latency: window valid 1 clk after the internal read strobe; a line starts 2 clk after the 3rd line fills.
// Backpressure: none on the output; pixels arriving while all four buffers are full are dropped.
// Ports: i_clk, i_rst_n (async active-low), bus (window_gen_if.slave): i_pixel_data,
// i_pixel_data_valid, o_pixel_data (byte row*3+col, row0 = oldest line), o_pixel_data_valid, o_intr.
// Option: WINDOW_GEN_READY_EN adds bus.o_pixel_ready = registered (fill < 4*LINE_WIDTH).
module window_gen
    import imgproc_pkg::*;
#(
    parameter int LINE_WIDTH = 512
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    window_gen_if.slave  bus
);
    localparam int PW = $clog2(LINE_WIDTH);
    localparam int FW = $clog2(4 * LINE_WIDTH + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(4 * LINE_WIDTH);
    localparam logic [FW-1:0] FILL_RD   = FW'(3 * LINE_WIDTH);
    localparam logic [FW-1:0] FILL_LINE = FW'(LINE_WIDTH);

    rd_state_t           state;
    logic [1:0]          wr_idx;
    logic [1:0]          rd_idx;
    logic [1:0]          rd_sel;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [FW-1:0]       fill;
    logic [FW-1:0]       fill_nxt;
    logic                wr_acc;
    logic                rd_en;
    logic                rd_last;
    logic [NUM_LB-1:0]   lb_wr;
    logic [NUM_LB-1:0]   lb_rd;
    logic [3*DATA_W-1:0] lb_dat [NUM_LB];

    assign wr_acc  = bus.i_pixel_data_valid && (fill != FILL_FULL);
    assign rd_en   = (state == RD);
    assign rd_last = rd_en && (rd_ptr == PW'(LINE_WIDTH - 3));

    always_comb begin
        fill_nxt = fill;
        if (wr_acc) begin
            fill_nxt = fill_nxt + 1'b1;
        end
        if (rd_last) begin
            fill_nxt = fill_nxt - FILL_LINE;
        end
    end

    // Writes steer to one buffer; reads enable the three consecutive buffers
    // starting at the oldest held line.
    always_comb begin
        lb_wr = '0;
        lb_rd = '0;
        lb_wr[wr_idx] = wr_acc;
        for (int k = 0; k < 3; k++) begin
            lb_rd[rd_idx + 2'(k)] = rd_en;
        end
    end

    for (genvar g = 0; g < NUM_LB; g++) begin : g_lb
        line_buf #(
            .LINE_WIDTH (LINE_WIDTH)
        ) u_lb (
            .i_clk        (i_clk),
            .i_rst_n      (i_rst_n),
            .i_data       (bus.i_pixel_data),
            .i_data_valid (lb_wr[g]),
            .i_rd_en      (lb_rd[g]),
            .o_data       (lb_dat[g])
        );
    end

    // rd_idx has already advanced when the last window of a line emerges, so the
    // output mux follows a copy taken alongside each read.
    assign bus.o_pixel_data = {lb_dat[rd_sel + 2'd2], lb_dat[rd_sel + 2'd1], lb_dat[rd_sel]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state                  <= IDLE;
            wr_idx                 <= '0;
            rd_idx                 <= '0;
            rd_sel                 <= '0;
            wr_ptr                 <= '0;
            rd_ptr                 <= '0;
            fill                   <= '0;
            bus.o_pixel_data_valid <= 1'b0;
            bus.o_intr             <= 1'b0;
        end else begin
            fill                   <= fill_nxt;
            bus.o_pixel_data_valid <= rd_en;
            bus.o_intr             <= rd_last;
            if (rd_en) begin
                rd_sel <= rd_idx;
            end
            if (wr_acc) begin
                if (wr_ptr == PW'(LINE_WIDTH - 1)) begin
                    wr_ptr <= '0;
                    wr_idx <= wr_idx + 2'd1;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (fill >= FILL_RD) begin
                        state  <= RD;
                        rd_ptr <= '0;
                    end
                end
                RD: begin
                    if (rd_last) begin
                        state  <= IDLE;
                        rd_ptr <= '0;
                        rd_idx <= rd_idx + 2'd1;
                    end else begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WINDOW_GEN_READY_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_pixel_ready <= 1'b1;
        end else begin
            bus.o_pixel_ready <= (fill_nxt != FILL_FULL);
        end
    end
`endif
endmodule

// File: tb/tb_window_gen.sv
// Purpose: self-checking bench for window_gen at LINE_WIDTH=8.
// Latency: n/a.
// Backpressure: the source never overruns (the output drains faster than it fills).
module tb_window_gen;
    localparam int LW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    window_gen_if bus_if ();

    window_gen #(.LINE_WIDTH(LW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_if)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]  pix[$];        // accepted pixels since the last reset
    int          wr_cnt = 0;    // accepted writes since the last reset
    int          mon_line = 0;  // output line currently being received
    int          mon_col  = 0;  // window index within that line
    logic [71:0] first_q[$];    // first window of each finished/started line
    logic [71:0] last_q[$];     // last window of each finished line
    logic        prev_intr = 1'b0;
    int          fill_d1 = 0;
    int          fill_d2 = 0;

    typedef struct {
        int npix;
        int lines;
        int first_p0;   // row0/col0 pixel of the first window of the last line
        int last_p0;    // row0/col0 pixel of the last window of the last line
    } vec_t;

    task automatic check(string name, logic [71:0] act, logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Window whose top-left pixel has value p0 for a stream where value = index.
    function automatic logic [71:0] exp_win(int p0);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(r*3+c)*8 +: 8] = 8'(p0 + r*LW + c);
        return w;
    endfunction

    // Output line n is built from input lines n, n+1, n+2 of the accepted stream.
    function automatic logic [71:0] model_win(int line, int col);
        logic [71:0] w;
        int idx;
        w = 'x;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                idx = (line + r) * LW + col + c;
                if (idx < pix.size()) w[(r*3+c)*8 +: 8] = pix[idx];
            end
        return w;
    endfunction

    // Continuous scoreboard for every emitted window.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_line = 0;
            mon_col  = 0;
            first_q.delete();
            last_q.delete();
            prev_intr = 1'b0;
            fill_d1 = 0;
            fill_d2 = 0;
        end else begin
            if (prev_intr)
                check("idle_after_line", 72'(bus_if.o_pixel_data_valid), 72'(0));
            if (bus_if.o_pixel_data_valid) begin
                check("window", bus_if.o_pixel_data, model_win(mon_line, mon_col));
                check("intr_at_col", 72'(bus_if.o_intr), 72'(mon_col == LW-3));
                if (mon_col == 0) begin
                    first_q.push_back(bus_if.o_pixel_data);
                    check("start_fill_ge_3lines", 72'(fill_d2 >= 3*LW), 72'(1));
                end
                if (mon_col == LW-3) begin
                    last_q.push_back(bus_if.o_pixel_data);
                    check("fill_after_release", 72'(dut.fill), 72'(wr_cnt - LW*(mon_line+1)));
                    mon_line++;
                    mon_col = 0;
                end else begin
                    mon_col++;
                end
            end else if (bus_if.o_intr || mon_col != 0) begin
                checks++;
                errors++;
                $display("FAIL line_gap: valid=0 intr=%0b col=%0d expected contiguous windows", bus_if.o_intr, mon_col);
            end
            prev_intr = bus_if.o_intr;
            fill_d2 = fill_d1;
            fill_d1 = int'(dut.fill);
        end
    end

    task automatic do_reset();
        #2 rst_n = 1'b0;
        bus_if.i_pixel_data_valid = 1'b0;
        pix.delete();
        wr_cnt = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Stream n pixels; gap_max>0 inserts random idle cycles; rnd picks random data.
    task automatic send(int n, int base, int gap_max, bit rnd);
        logic [7:0] v;
        for (int i = 0; i < n; i++) begin
            bus_if.i_pixel_data_valid = 1'b0;
            if (gap_max > 0) repeat ($urandom_range(gap_max)) begin @(posedge clk); #1; end
            v = rnd ? 8'($urandom) : 8'(base + i);
            bus_if.i_pixel_data       = v;
            bus_if.i_pixel_data_valid = 1'b1;
            pix.push_back(v);
            @(posedge clk);
            #1 wr_cnt++;
        end
        bus_if.i_pixel_data_valid = 1'b0;
    endtask

    vec_t vecs[4];
    int   seen;

    initial begin
        bus_if.i_pixel_data       = '0;
        bus_if.i_pixel_data_valid = 1'b0;
        vecs[0] = '{npix: 24, lines: 1, first_p0: 0,  last_p0: 5};
        vecs[1] = '{npix: 32, lines: 2, first_p0: 8,  last_p0: 13};
        vecs[2] = '{npix: 40, lines: 3, first_p0: 16, last_p0: 21};
        vecs[3] = '{npix: 48, lines: 4, first_p0: 24, last_p0: 29};

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_data",  bus_if.o_pixel_data, 72'(0));
        check("rst_valid", 72'(bus_if.o_pixel_data_valid), 72'(0));
        check("rst_intr",  72'(bus_if.o_intr), 72'(0));
        check("rst_fill",  72'(dut.fill), 72'(0));

        // Table: stream from index 0, compare line count and the last line's end windows.
        for (int t = 0; t < 4; t++) begin
            do_reset();
            send(vecs[t].npix, 0, 0, 1'b0);
            repeat (40) @(posedge clk);
            @(negedge clk);
            check($sformatf("lines_%0d", t), 72'(last_q.size()), 72'(vecs[t].lines));
            if (last_q.size() == vecs[t].lines) begin
                check($sformatf("first_win_%0d", t), first_q[vecs[t].lines-1], exp_win(vecs[t].first_p0));
                check($sformatf("last_win_%0d", t),  last_q[vecs[t].lines-1],  exp_win(vecs[t].last_p0));
            end
        end

        // Asynchronous reset during the 3rd window of a line.
        do_reset();
        send(24, 0, 0, 1'b0);
        seen = 0;
        for (int k = 0; k < 200 && seen < 3; k++) begin
            @(negedge clk);
            if (bus_if.o_pixel_data_valid) seen++;
        end
        check("third_window_seen", 72'(seen), 72'(3));
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid_now", 72'(bus_if.o_pixel_data_valid), 72'(0));
        check("arst_data_now",  bus_if.o_pixel_data, 72'(0));
        check("arst_intr_now",  72'(bus_if.o_intr), 72'(0));
        pix.delete();
        wr_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("arst_hold_valid", 72'(bus_if.o_pixel_data_valid), 72'(0));
            check("arst_hold_intr",  72'(bus_if.o_intr), 72'(0));
        end
        check("arst_hold_data", bus_if.o_pixel_data, 72'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(24, 100, 0, 1'b0);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("post_rst_lines", 72'(last_q.size()), 72'(1));
        if (last_q.size() == 1) begin
            check("post_rst_first", first_q[0], exp_win(100));
            check("post_rst_last",  last_q[0],  exp_win(105));
        end

        // Random data with random input gaps: 6 lines in -> 4 lines out.
        do_reset();
        send(6*LW, 0, 3, 1'b1);
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("rand_gap_lines", 72'(last_q.size()), 72'(4));

        // Random data, continuous stream: 5 lines in -> 3 lines out.
        do_reset();
        send(5*LW, 0, 0, 1'b1);
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("rand_cont_lines", 72'(last_q.size()), 72'(3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
